// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_BYTES      = 1;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// 4-lane little-endian insert register: i_load writes i_byte into lane i_lane; i_clear zeroes the word.
module byte_packer
   import prog_loader_pkg::*;
(
   input  logic                          i_clk,
   input  logic                          i_clear,
   input  logic                          i_load,
   input  logic [1:0]                    i_lane,
   input  logic [7:0]                    i_byte,
   output logic [8*BYTES_PER_WORD-1:0]   o_word
);

   logic [8*BYTES_PER_WORD-1:0] r_word;

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_word <= '0;
      end else if (i_load) begin
         for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i_lane == 2'(i)) r_word[8*i +: 8] <= i_byte;
         end
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader into instruction memory; holds the CPU while loading.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte_data,
   output logic              o_byte_ready,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_waddr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_cpu_hold,
   output logic              o_done,
   output logic              o_err
);

`ifdef LOADER_CHECKSUM_EN
   localparam state_t ST_LAST = ST_CSUM;
`else
   localparam state_t ST_LAST = ST_DONE;
`endif

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W:0]   r_word_idx;
   logic [ADDR_W:0]   r_n;
   logic [1:0]        r_byte_idx;
   logic [ADDR_W:0]   w_word_nxt;
   logic              w_xfer;
   logic              w_start_take;
   logic              w_load;
   logic [31:0]       w_word;

   assign w_xfer       = i_byte_valid && o_byte_ready;
   assign w_start_take = i_start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
   assign w_load       = w_xfer && (r_state == ST_DATA);
   assign w_word_nxt   = r_word_idx + {{ADDR_W{1'b0}}, 1'b1};

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] r_csum;

   always_ff @(posedge i_clk) begin
      if (i_rst || w_start_take) r_csum <= '0;
      else if (w_load)           r_csum <= r_csum ^ i_byte_data;
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (i_start) w_state_nxt = ST_HDR;
         end
         ST_HDR: begin
            if (w_xfer) begin
               if (i_byte_data == 8'd0)               w_state_nxt = ST_LAST;
               else if (int'(i_byte_data) > DEPTH)    w_state_nxt = ST_ERR;
               else                                   w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_xfer && r_byte_idx == 2'(BYTES_PER_WORD - 1)) w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            w_state_nxt = (w_word_nxt == r_n) ? ST_LAST : ST_DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (w_xfer) w_state_nxt = (i_byte_data == r_csum) ? ST_DONE : ST_ERR;
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Header width fits in ADDR_W+1 bits whenever it passes the DEPTH check.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_start_take) begin
         r_word_idx <= '0;
         r_byte_idx <= '0;
         r_n        <= '0;
      end else begin
         if (r_state == ST_HDR && w_xfer) r_n <= i_byte_data[ADDR_W:0];
         if (w_load) r_byte_idx <= r_byte_idx + 2'd1;
         if (r_state == ST_WRITE) begin
            r_word_idx <= w_word_nxt;
            r_byte_idx <= '0;
         end
      end
   end

   byte_packer u_packer (
      .i_clk   (i_clk),
      .i_clear (i_rst || w_start_take),
      .i_load  (w_load),
      .i_lane  (r_byte_idx),
      .i_byte  (i_byte_data),
      .o_word  (w_word)
   );

   // Outputs decode only flopped state, so they move only on the clock edge.
   always_comb begin
      o_byte_ready = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);
      o_imem_we    = (r_state == ST_WRITE);
      o_cpu_hold   = (r_state != ST_IDLE) && (r_state != ST_DONE);
      o_done       = (r_state == ST_DONE);
      o_err        = (r_state == ST_ERR);
      o_imem_waddr = r_word_idx[ADDR_W-1:0];
      o_imem_wdata = w_word;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the instruction memory before the CPU runs. It accepts a length-prefixed stream of bytes over a valid/ready handshake and packs them little-endian into 32-bit words. It writes those words through the instruction memory's write port at word addresses 0, 1, 2, … and holds the CPU in reset while loading. It is the writer-side counterpart of the CPU's asynchronous word-read port on the instruction memory.

## Interface
- `ADDR_W`, 6, instruction-memory word-address width
- `DEPTH`, 64, number of instruction words; the header word count must be ≤ DEPTH
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- `byte_valid` in 1: stream byte present
- `byte_data` in 8: stream byte
- `byte_ready` out 1: loader can accept a byte; a transfer occurs when `byte_valid && byte_ready` at a rising edge
- `imem_we` out 1: one-cycle instruction-memory write strobe
- `imem_waddr` out ADDR_W: word address
- `imem_wdata` out 32: word to write
- `cpu_hold` out 1: keeps the CPU in reset while high
- `done` out 1: level; load completed successfully
- `err` out 1: level; load aborted

## Operation
- **Stream format:**
  - 1 header byte N (word count).
  - Then 4·N payload bytes, least-significant byte first per word.
  - With `LOADER_CHECKSUM_EN`, one trailing checksum byte follows.
- **States:** IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
- **IDLE → HDR** on `start`.
  - `cpu_hold`=1; `done`=`err`=0; word index=0; byte index=0.
- **HDR**
  - `byte_ready`=1.
  - On transfer: N=0 → DONE (or CSUM when enabled).
  - N>DEPTH → ERR.
  - Otherwise latch N → DATA.
- **DATA**
  - `byte_ready`=1.
  - Each transfer shifts the byte into lane `byte_idx`, i.e. `word[8*byte_idx +: 8]`, then `byte_idx++`.
  - On the 4th byte (`byte_idx`=3) → WRITE.
- **WRITE**
  - `byte_ready`=0; `imem_we`=1 for exactly this cycle.
  - `imem_waddr`=word index; `imem_wdata`=packed word.
  - Then `word_idx++`, `byte_idx`=0.
  - If `word_idx`+1 == N → DONE (or CSUM); else → DATA.
- **CSUM**
  - `byte_ready`=1; accept one byte.
  - Equals the XOR of all payload bytes → DONE; else → ERR.
- **DONE:** `done`=1, `cpu_hold`=0, `byte_ready`=0. Remains until `start`.
- **ERR:**
  - `err`=1, `cpu_hold`=1 (CPU never runs a partial image), `byte_ready`=0. Remains until `start`.
  - Words already written are not cleared.
- **Restart:** `start` in DONE/ERR re-enters HDR with `cpu_hold`=1 and flags cleared in the same edge.
- **Ignored inputs:**
  - `start` in HDR/DATA/WRITE/CSUM is ignored.
  - `byte_valid` while `byte_ready`=0 is ignored; the byte is not consumed.
- **Address width:** the word index is ADDR_W+1 bits internally, so N=DEPTH is representable. `imem_waddr` is its low ADDR_W bits; no wrap occurs because N ≤ DEPTH.

## Timing
- **Reset values:**
  - State IDLE.
  - `byte_ready`, `imem_we`, `cpu_hold`, `done`, `err` = 0.
  - `imem_waddr`=0, `imem_wdata`=0; counters and checksum 0.
- **`rst` mid-load:** returns to IDLE next edge and drops `cpu_hold`. Any partial word is discarded and never written.
- **Output registration:** all outputs are registered and change only on rising `clk`.
- **Write latency:** the 4th byte accepted at edge k → `imem_we` high in cycle k+1 → next byte accepted no earlier than edge k+2.
- **Throughput:** 5 cycles per word at full `byte_valid` rate.
- **Hold release:** `cpu_hold` falls on the same edge that raises `done`, one cycle after the last write (or after the checksum byte).
- **Back-to-back:** `byte_ready` may be high on consecutive cycles within HDR/DATA. Bytes may arrive with arbitrary gaps.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - CSUM state is present; a running XOR of payload bytes is kept.
  - A trailing byte is required; a mismatch → ERR.
- **Not defined:**
  - CSUM state and XOR register are removed.
  - The last WRITE (or N=0 header) goes directly to DONE; no trailing byte is consumed.

## Structure
- **Package `prog_loader_pkg`:**
  - State enum type.
  - Constants `BYTES_PER_WORD`=4 and `HDR_BYTES`=1.
- **Sub-module `byte_packer`:**
  - 4-lane little-endian shift/insert register.
  - Inputs: byte, lane index, load strobe, clear.
  - Output: 32-bit word.
- The loader FSM instantiates `byte_packer` once.

## Test plan
- **Three-word load:** `start`, header 3, bytes 93 8F 1F 00 | 93 8F 1F 00 | 0F 00 F0 0F.
  - Expect writes addr0=0x001F8F93, addr1=0x001F8F93, addr2=0x0FF0000F.
  - Expect `done`=1 and `cpu_hold`=0 one cycle after the last write.
- **Empty image:** header 0 → no `imem_we`; `done` next cycle.
- **Oversize header:** header 65 (DEPTH=64) → ERR, `err`=1, `cpu_hold`=1, no writes.
- **Reset mid-load:** after 2 of 4 bytes of word 1, pulse `rst`.
  - Expect all outputs 0 and no further write.
  - A fresh `start` plus a full stream then loads correctly from addr 0.
- **Gapped stream, full image:** `byte_valid` toggling every other cycle with header 64.
  - Expect 64 writes at addresses 0..63 with correct data; last address 63; `done`.
- **Checksum mode:** with `LOADER_CHECKSUM_EN`, header 1, bytes 73 00 10 00.
  - Checksum 0x63 → `done`.
  - Checksum 0x62 → `err` with `cpu_hold`=1.
